disparity_engine: RTL
=====================

# disparity_engine

Parametrised block-matching stereo disparity engine, successor to the fixed-size `disparity` FSM. It fetches left/right pixels from the external frame buffer over the existing href/vref/image_sel interface and computes a BLK×BLK sum of absolute differences (SAD) for each candidate disparity. The best disparity per output position is written to an internal result RAM, which the display path reads back through disp_href/disp_vref.

## Interface
- WIDTH, 20: input image width in pixels (≤1024)
- HEIGHT, 7: input image height (≤1024)
- BLK, 3: square match window edge (≥1, odd not required)
- MAX_DISP, 4: number of candidate disparities 0..MAX_DISP-1 (≥1)
- PIX_W, 8: pixel width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  start pulse; sampled only in IDLE
- image_data  in  PIX_W  pixel at current buffer address; combinational from buffer, sampled on the next clk edge
- buffer_ready  in  1  buffer data valid; low stalls fetches
- disp_href, disp_vref  in  10 each  result readback column/row
- buffer_href, buffer_vref  out  10 each  pixel fetch address
- image_sel  out  1  0 = left image, 1 = right image
- new_image  out  RES_W  registered result word at (disp_href, disp_vref)
- idle  out  1  high in IDLE
- done  out  1  one-cycle pulse when the last result is written
- state_LED  out  3  current state encoding

## Operation
- Derived values: OUT_W = WIDTH-BLK+1-(MAX_DISP-1); OUT_H = HEIGHT-BLK+1; DW = max(1, clog2(MAX_DISP)); SADW = PIX_W + clog2(BLK*BLK); RES_W = SADW+DW.
- States: IDLE=000, FETCH_L=001, FETCH_R=010, COMPARE=011, WRITE=100.
- Counters: block x (0..OUT_W-1), y (0..OUT_H-1); disparity d; window i (row), j (col).
- IDLE: enable=1 clears x, y, d, i, j, sad, best_sad (all ones), and best_d → FETCH_L. enable outside IDLE is ignored.
- FETCH_L: address (MAX_DISP-1+x+j, y+i), image_sel=0; capture L on the edge when buffer_ready=1 → FETCH_R.
- FETCH_R: address (MAX_DISP-1+x+j-d, y+i), image_sel=1; when buffer_ready=1, sad += |L-image_data|. Advance j then i. After the last window pixel go → COMPARE, else → FETCH_L.
- COMPARE: if sad < best_sad (strict, so ties keep the lower d), update best_sad and best_d. Clear sad. If d=MAX_DISP-1 → WRITE, else d++ → FETCH_L.
- WRITE: store result {best_sad, best_d} at index y*OUT_W+x and reset best registers. Advance x then y. After the last block, pulse done → IDLE; otherwise → FETCH_L.
- SAD cannot overflow because SADW is sized for the worst case. Unsigned absolute difference.
- Readback: new_image registered one cycle after disp_href/disp_vref. Out-of-range coordinates (href ≥ OUT_W or vref ≥ OUT_H) return 0. Reads are allowed in any state; a read and a write to the same index in the same cycle returns the old data.

## Timing
- Reset values: buffer_href=0, buffer_vref=0, image_sel=0, new_image=0, idle=1, done=0, state_LED=000. Result RAM is not cleared.
- Reset mid-operation forces IDLE on the next edge. A partial frame is abandoned with no done pulse; RAM holds stale or partial data.
- Cycles per block: MAX_DISP*(2*BLK²+1)+1. Frame time: OUT_W*OUT_H*that, plus 1 start cycle, with no stalls.
- buffer_ready low in FETCH_L/FETCH_R holds state, address, and image_sel with no accumulation. Each low cycle adds exactly one cycle of latency. buffer_ready is ignored in other states.

## Configuration
- DISP_SAD_OUT_EN defined: the RAM stores and new_image returns best_sad in bits [RES_W-1:DW] as a confidence value.
- DISP_SAD_OUT_EN undefined: the RAM is DW bits wide and new_image[RES_W-1:DW] reads 0. Port width is unchanged.

## Structure
- disparity_pkg: state encodings, a clog2 function, and derived-width helpers (DW, SADW, RES_W).
- One sub-module, sad_result_ram: simple dual-port RAM with a write port from the engine and a registered read port with out-of-range zeroing.

## Test plan
Defaults throughout (OUT_W=15, OUT_H=5, 77 cycles/block, 5776 cycles/frame).
- L=R=horizontal ramp (pixel = x) → every result best_d=0, SAD 0. done pulses 5776 cycles after enable, then idle=1.
- Pattern of distinct values, R[x]=L[x+2] → every result best_d=2. With DISP_SAD_OUT_EN, upper field = 0.
- Same as the previous case with buffer_ready low for 10 cycles during FETCH_R of block (3,1) → identical results, done delayed by exactly 10 cycles.
- Constant L=10, R=30 → SAD 180 for all d; ties give best_d=0. new_image upper field = 180 with the macro, 0 without.
- reset asserted in COMPARE of block (5,2) → next cycle state_LED=000, idle=1, buffer_href/vref=0, no done. Re-enable produces correct full results.
- Readback disp_href=15, disp_vref=0 → new_image=0 one cycle later. enable pulse during FETCH_L is ignored and the frame completes normally.

Source files
------------

// File: rtl/disparity_pkg.sv
// Shared state encoding and width helpers for the disparity engine and its result RAM.
package disparity_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH_L = 3'b001,
    S_FETCH_R = 3'b010,
    S_COMPARE = 3'b011,
    S_WRITE   = 3'b100
  } state_e;

  // Frame-buffer and readback coordinates are always 10 bits wide.
  localparam int COORD_W = 10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) begin
        result = k + 1;
      end
    end
    return result;
  endfunction

  function automatic int calc_dw(input int max_disp);
    return (clog2(max_disp) > 0) ? clog2(max_disp) : 1;
  endfunction

  function automatic int calc_sadw(input int pix_w, input int blk);
    return pix_w + clog2(blk * blk);
  endfunction

  function automatic int calc_res_w(input int pix_w, input int blk, input int max_disp);
    return calc_sadw(pix_w, blk) + calc_dw(max_disp);
  endfunction

endpackage

// File: rtl/sad_result_ram.sv
// Result RAM of the disparity engine: one write port, registered read port that returns 0 outside the grid.
// The stored word width MEM_W is picked by the engine (DISP_SAD_OUT_EN keeps best_sad next to best_d).
module sad_result_ram
  import disparity_pkg::*;
#(
  parameter int OUT_W = 15,
  parameter int OUT_H = 5,
  parameter int DEPTH = 75,
  parameter int AW    = 7,
  parameter int MEM_W = 2,
  parameter int RES_W = 14
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [MEM_W-1:0]   wr_data_i,
  input  logic [COORD_W-1:0] rd_col_i,
  input  logic [COORD_W-1:0] rd_row_i,
  output logic [RES_W-1:0]   rd_data_o
);

  logic [MEM_W-1:0] mem_q [DEPTH];
  logic [RES_W-1:0] rd_data_q;
  logic [RES_W-1:0] rd_data_d;
  logic             in_range_s;
  logic [AW-1:0]    rd_addr_s;

  // One extra bit so a 1024-wide grid still compares correctly.
  assign in_range_s = ({1'b0, rd_col_i} < (COORD_W + 1)'(OUT_W)) &&
                      ({1'b0, rd_row_i} < (COORD_W + 1)'(OUT_H));
  assign rd_addr_s  = AW'(rd_row_i) * AW'(OUT_W) + AW'(rd_col_i);

  // Select the stored word or zero for coordinates outside the output grid.
  always_comb begin
    rd_data_d = {RES_W{1'b0}};
    if (in_range_s) begin
      rd_data_d = RES_W'(mem_q[rd_addr_s]);
    end else begin
      rd_data_d = {RES_W{1'b0}};
    end
  end

  // Result storage; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; a same-cycle write to the same index is seen only on the next read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= {RES_W{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/disparity_engine.sv
// Block-matching stereo disparity engine: per output block, SAD over BLKxBLK for every disparity, best d stored.
// Build option DISP_SAD_OUT_EN stores best_sad as a confidence field above best_d in the result word.
module disparity_engine
  import disparity_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int HEIGHT   = 7,
  parameter int BLK      = 3,
  parameter int MAX_DISP = 4,
  parameter int PIX_W    = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [PIX_W-1:0]                            image_data,
  input  logic                                        buffer_ready,
  input  logic [COORD_W-1:0]                          disp_href,
  input  logic [COORD_W-1:0]                          disp_vref,
  output logic [COORD_W-1:0]                          buffer_href,
  output logic [COORD_W-1:0]                          buffer_vref,
  output logic                                        image_sel,
  output logic [calc_res_w(PIX_W, BLK, MAX_DISP)-1:0] new_image,
  output logic                                        idle,
  output logic                                        done,
  output logic [2:0]                                  state_LED
);

  localparam int OUT_W = WIDTH - BLK + 1 - (MAX_DISP - 1);
  localparam int OUT_H = HEIGHT - BLK + 1;
  localparam int DW    = calc_dw(MAX_DISP);
  localparam int SADW  = calc_sadw(PIX_W, BLK);
  localparam int RES_W = calc_res_w(PIX_W, BLK, MAX_DISP);
  localparam int DEPTH = OUT_W * OUT_H;
  localparam int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
`ifdef DISP_SAD_OUT_EN
  localparam int MEM_W = RES_W;
`else
  localparam int MEM_W = DW;
`endif

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(OUT_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(OUT_H - 1);
  localparam logic [COORD_W-1:0] WIN_LAST = COORD_W'(BLK - 1);
  localparam logic [COORD_W-1:0] ORIGIN   = COORD_W'(MAX_DISP - 1);
  localparam logic [COORD_W-1:0] C_ZERO   = 10'd0;
  localparam logic [COORD_W-1:0] C_ONE    = 10'd1;
  localparam logic [DW-1:0]      D_LAST   = DW'(MAX_DISP - 1);
  localparam logic [DW-1:0]      D_ZERO   = DW'(0);
  localparam logic [DW-1:0]      D_ONE    = DW'(1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, i_q, i_d, j_q, j_d;
  logic [DW-1:0]      d_q, d_d, best_d_q, best_d_d;
  logic [PIX_W-1:0]   l_q, l_d, abs_diff_s;
  logic [SADW-1:0]    sad_q, sad_d, best_sad_q, best_sad_d;
  logic [COORD_W-1:0] href_q, href_d, vref_q, vref_d;
  logic               sel_q, sel_d, done_q, done_d, we_s;
  logic [AW-1:0]      waddr_s;
  logic [MEM_W-1:0]   wdata_s;

  assign abs_diff_s = (l_q >= image_data) ? (l_q - image_data) : (image_data - l_q);

  // Sequencing of window pixels, disparities and blocks; a low buffer_ready freezes the fetch states.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    i_d        = i_q;
    j_d        = j_q;
    d_d        = d_q;
    l_d        = l_q;
    sad_d      = sad_q;
    best_sad_d = best_sad_q;
    best_d_d   = best_d_q;
    done_d     = 1'b0;
    we_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          x_d        = C_ZERO;
          y_d        = C_ZERO;
          i_d        = C_ZERO;
          j_d        = C_ZERO;
          d_d        = D_ZERO;
          sad_d      = {SADW{1'b0}};
          best_sad_d = {SADW{1'b1}};
          best_d_d   = D_ZERO;
          state_d    = S_FETCH_L;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH_L: begin
        if (buffer_ready) begin
          l_d     = image_data;
          state_d = S_FETCH_R;
        end else begin
          state_d = S_FETCH_L;
        end
      end
      S_FETCH_R: begin
        if (buffer_ready) begin
          sad_d = sad_q + SADW'(abs_diff_s);
          if (j_q == WIN_LAST) begin
            j_d = C_ZERO;
            if (i_q == WIN_LAST) begin
              i_d     = C_ZERO;
              state_d = S_COMPARE;
            end else begin
              i_d     = i_q + C_ONE;
              state_d = S_FETCH_L;
            end
          end else begin
            j_d     = j_q + C_ONE;
            state_d = S_FETCH_L;
          end
        end else begin
          state_d = S_FETCH_R;
        end
      end
      S_COMPARE: begin
        // Strict compare: on a tie the earlier (lower) disparity wins.
        if (sad_q < best_sad_q) begin
          best_sad_d = sad_q;
          best_d_d   = d_q;
        end else begin
          best_sad_d = best_sad_q;
        end
        sad_d = {SADW{1'b0}};
        if (d_q == D_LAST) begin
          d_d     = D_ZERO;
          state_d = S_WRITE;
        end else begin
          d_d     = d_q + D_ONE;
          state_d = S_FETCH_L;
        end
      end
      S_WRITE: begin
        we_s       = 1'b1;
        best_sad_d = {SADW{1'b1}};
        best_d_d   = D_ZERO;
        if (x_q == X_LAST) begin
          x_d = C_ZERO;
          if (y_q == Y_LAST) begin
            y_d     = C_ZERO;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            y_d     = y_q + C_ONE;
            state_d = S_FETCH_L;
          end
        end else begin
          x_d     = x_q + C_ONE;
          state_d = S_FETCH_L;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch address for the state being entered, so the registered address is valid throughout it.
  always_comb begin
    href_d = C_ZERO;
    vref_d = C_ZERO;
    sel_d  = 1'b0;
    case (state_d)
      S_FETCH_L: begin
        href_d = ORIGIN + x_d + j_d;
        vref_d = y_d + i_d;
        sel_d  = 1'b0;
      end
      S_FETCH_R: begin
        href_d = ORIGIN + x_d + j_d - COORD_W'(d_d);
        vref_d = y_d + i_d;
        sel_d  = 1'b1;
      end
      default: begin
        href_d = C_ZERO;
        vref_d = C_ZERO;
        sel_d  = 1'b0;
      end
    endcase
  end

  // State, counters, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= C_ZERO;
      y_q        <= C_ZERO;
      i_q        <= C_ZERO;
      j_q        <= C_ZERO;
      d_q        <= D_ZERO;
      l_q        <= {PIX_W{1'b0}};
      sad_q      <= {SADW{1'b0}};
      best_sad_q <= {SADW{1'b1}};
      best_d_q   <= D_ZERO;
      href_q     <= C_ZERO;
      vref_q     <= C_ZERO;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      i_q        <= i_d;
      j_q        <= j_d;
      d_q        <= d_d;
      l_q        <= l_d;
      sad_q      <= sad_d;
      best_sad_q <= best_sad_d;
      best_d_q   <= best_d_d;
      href_q     <= href_d;
      vref_q     <= vref_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
    end
  end

  assign waddr_s = AW'(y_q) * AW'(OUT_W) + AW'(x_q);
`ifdef DISP_SAD_OUT_EN
  assign wdata_s = {best_sad_q, best_d_q};
`else
  assign wdata_s = best_d_q;
`endif

  sad_result_ram #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .DEPTH (DEPTH),
    .AW    (AW),
    .MEM_W (MEM_W),
    .RES_W (RES_W)
  ) u_result_ram (
    .clk_i     (clk),
    .reset_i   (reset),
    .we_i      (we_s),
    .wr_addr_i (waddr_s),
    .wr_data_i (wdata_s),
    .rd_col_i  (disp_href),
    .rd_row_i  (disp_vref),
    .rd_data_o (new_image)
  );

  assign buffer_href = href_q;
  assign buffer_vref = vref_q;
  assign image_sel   = sel_q;
  assign idle        = (state_q == S_IDLE);
  assign done        = done_q;
  assign state_LED   = state_q;

endmodule
